// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared types and helpers for the serial-in/parallel-out frame controller.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int WIDTH_MAX = 32;

  // Bit-count register width able to hold the value width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Returns 1 when v holds an odd number of ones.
  function automatic logic odd_ones(input logic [WIDTH_MAX-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// Serial input / parallel output bundle of the frame controller.
// master: serial front-end plus word consumer; slave: the controller.
interface sipo_frame_ctrl_if #(parameter int WIDTH = 8);

  logic             frame_start;
  logic             sin;
  logic             sin_vld;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output frame_start, sin, sin_vld, dout_rdy,
    input  dout, dout_vld, busy, overrun, parity_err
  );

  modport slave (
    input  frame_start, sin, sin_vld, dout_rdy,
    output dout, dout_vld, busy, overrun, parity_err
  );

endinterface

// File: rtl/sipo_frame_ctrl_shift_core.sv
// Pure shift stage: optional clear, then optional one-bit shift per cycle.
// A clear together with an enable yields a stage holding only the new bit.
module sipo_shift_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] base_s;

  // Next stage value: clear first, then shift d in toward the far end
  always_comb begin
    base_s = q_q;
    q_d    = q_q;
    if (clr) begin
      base_s = {WIDTH{1'b0}};
    end else begin
      base_s = q_q;
    end
    if (en) begin
      if (MSB_FIRST) begin
        q_d = {base_s[WIDTH-2:0], d};
      end else begin
        q_d = {d, base_s[WIDTH-1:1]};
      end
    end else begin
      q_d = base_s;
    end
  end

  // Stage register
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for a serial-in/parallel-out capture path.
// Optional parity bit per frame: define SIPO_FRAME_PARITY_EN.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_,
  sipo_frame_ctrl_if.slave      bus
);

  localparam int            CW     = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);
`ifdef SIPO_FRAME_PARITY_EN
  localparam logic [CW-1:0] FULL_C = CW'(WIDTH);
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_vld_q, dout_vld_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             parity_err_q, parity_err_d;

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_s;
  logic             clr_s;
  logic             en_s;
  logic             done_s;
  logic             perr_s;
  logic             out_free_s;

`ifndef SIPO_FRAME_PARITY_EN
  // Word as it will stand once the current bit is shifted in.
  logic [WIDTH-1:0] shifted_s;
  assign shifted_s = MSB_FIRST ? {shift_q[WIDTH-2:0], bus.sin}
                               : {bus.sin, shift_q[WIDTH-1:1]};
`endif

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .rst_ (rst_),
    .clr  (clr_s),
    .en   (en_s),
    .d    (bus.sin),
    .q    (shift_q)
  );

  // Frame sequencing: start/abort, bit counting and completion detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_s   = 1'b0;
    en_s    = 1'b0;
    done_s  = 1'b0;
    perr_s  = 1'b0;
    word_s  = shift_q;
    if (bus.frame_start) begin
      // Start or restart; a same-cycle strobe is bit 0.
      state_d = SHIFT;
      clr_s   = 1'b1;
      en_s    = bus.sin_vld;
      cnt_d   = bus.sin_vld ? CW'(1'b1) : CW'(1'b0);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SHIFT: begin
          if (bus.sin_vld) begin
            en_s = 1'b1;
            if (cnt_q == LAST_C) begin
`ifdef SIPO_FRAME_PARITY_EN
              state_d = PARITY;
              cnt_d   = FULL_C;
`else
              done_s  = 1'b1;
              word_s  = shifted_s;
              state_d = IDLE;
              cnt_d   = CW'(1'b0);
`endif
            end else begin
              cnt_d = cnt_q + CW'(1'b1);
            end
          end else begin
            state_d = SHIFT;
          end
        end
        PARITY: begin
`ifdef SIPO_FRAME_PARITY_EN
          if (bus.sin_vld) begin
            done_s  = 1'b1;
            word_s  = shift_q;
            perr_s  = odd_ones(WIDTH_MAX'(shift_q)) ^ bus.sin;
            state_d = IDLE;
            cnt_d   = CW'(1'b0);
          end else begin
            state_d = PARITY;
          end
`else
          state_d = IDLE;
          cnt_d   = CW'(1'b0);
`endif
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CW'(1'b0);
        end
      endcase
    end
  end

  // Output holding register: load a completed word if free, else flag overrun
  always_comb begin
    out_free_s   = ~dout_vld_q | bus.dout_rdy;
    dout_d       = dout_q;
    dout_vld_d   = dout_vld_q & ~bus.dout_rdy;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;
    busy_d       = (state_d != IDLE);
    if (done_s) begin
      parity_err_d = perr_s;
      if (out_free_s) begin
        dout_d     = word_s;
        dout_vld_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else begin
      parity_err_d = 1'b0;
    end
  end

  // State, count and output registers
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      cnt_q        <= CW'(1'b0);
      dout_q       <= {WIDTH{1'b0}};
      dout_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = dout_vld_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
  assign bus.parity_err = parity_err_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Bench for sipo_frame_ctrl: an LSB-first and an MSB-first instance share one
// stimulus stream; a frame-level model predicts every output each cycle.
module tb_sipo_frame_ctrl;

  localparam int W  = 8;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0;
  logic rst_;
  logic fs, s, v, rdy;

  sipo_frame_ctrl_if #(.WIDTH(W)) bus0 ();
  sipo_frame_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus0.frame_start = fs;
  assign bus0.sin         = s;
  assign bus0.sin_vld     = v;
  assign bus0.dout_rdy    = rdy;
  assign bus1.frame_start = fs;
  assign bus1.sin         = s;
  assign bus1.sin_vld     = v;
  assign bus1.dout_rdy    = rdy;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_(rst_), .bus(bus0));
  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_(rst_), .bus(bus1));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level model state
  logic         m_act;
  int           m_n;
  logic         m_buf [0:NB-1];
  logic [W-1:0] m_dout0, m_dout1;
  logic         m_vld, m_busy, m_ovr, m_perr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 1'b0; m_n = 0;
    m_dout0 = '0; m_dout1 = '0;
    m_vld = 1'b0; m_busy = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  // Collect bits of the current frame; when a full frame is present, build the
  // word for each bit order and offer it to the single-entry output slot.
  task automatic model_update();
    logic         done;
    logic [W-1:0] w0, w1;
    logic         p;
    logic         nv;
    done = 1'b0; w0 = '0; w1 = '0; p = 1'b0;
    if (fs) begin
      m_act = 1'b1; m_n = 0;
      if (v) begin m_buf[m_n] = s; m_n++; end
    end else if (m_act && v) begin
      m_buf[m_n] = s; m_n++;
    end
    if (m_act && m_n == NB) begin
      done = 1'b1;
      for (int i = 0; i < W; i++) begin
        w0[i]       = m_buf[i];
        w1[W-1-i]   = m_buf[i];
      end
      for (int i = 0; i < NB; i++) p = p ^ m_buf[i];
      m_act = 1'b0; m_n = 0;
    end
    nv = m_vld && !rdy;
    m_ovr = 1'b0; m_perr = 1'b0;
    if (done) begin
      if (NB > W) m_perr = p;
      if (!m_vld || rdy) begin
        m_dout0 = w0; m_dout1 = w1; nv = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
    m_vld  = nv;
    m_busy = m_act;
  endtask

  // Compare every DUT output with the model once per cycle
  always @(negedge clk) begin
    check("dout_lsb", bus0.dout, m_dout0);
    check("dout_msb", bus1.dout, m_dout1);
    check("dout_vld", {bus1.dout_vld, bus0.dout_vld}, {m_vld, m_vld});
    check("busy", {bus1.busy, bus0.busy}, {m_busy, m_busy});
    check("overrun", {bus1.overrun, bus0.overrun}, {m_ovr, m_ovr});
    check("parity_err", {bus1.parity_err, bus0.parity_err}, {m_perr, m_perr});
  end

  task automatic cyc(input logic f, input logic sd, input logic vd, input logic r);
    fs = f; s = sd; v = vd; rdy = r;
    @(posedge clk);
    if (!rst_) model_reset();
    else model_update();
    @(negedge clk);
    #1;
  endtask

  // Start pulse, W data bits LSB of w first, then (parity build) the even
  // parity bit, optionally inverted; rl is the ready level on the last edge.
  task automatic send_word(input logic [W-1:0] w, input logic rb, input logic rl, input logic flip);
    cyc(1'b1, 1'b0, 1'b0, rb);
    for (int i = 0; i < W; i++)
      cyc(1'b0, w[i], 1'b1, (NB == W && i == W - 1) ? rl : rb);
    if (NB > W) cyc(1'b0, (^w) ^ flip, 1'b1, rl);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ = 1'b0; fs = 1'b0; s = 1'b0; v = 1'b0; rdy = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_vld", bus0.dout_vld, 1'b0);
    check("rst_busy", bus0.busy, 1'b0);
    check("rst_dout", bus0.dout, 8'h00);
    rst_ = 1'b1;

    // Strobes without a start are ignored
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    check("idle_busy", bus0.busy, 1'b0);

    // Basic frame, both bit orders
    send_word(8'h4D, 1'b1, 1'b1, 1'b0);
    check("t1_dout_lsb", bus0.dout, 8'h4D);
    check("t1_dout_msb", bus1.dout, 8'hB2);
    check("t1_vld", bus0.dout_vld, 1'b1);
    check("t1_perr", bus0.parity_err, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_vld_drop", bus0.dout_vld, 1'b0);

    // Backpressure: second word dropped
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    check("t3_vld_a", bus0.dout_vld, 1'b1);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    check("t3_ovr", bus0.overrun, 1'b1);
    check("t3_keep", bus0.dout, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("t3_ovr_pulse", bus0.overrun, 1'b0);
    check("t3_vld_hold", bus0.dout_vld, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_vld_drop", bus0.dout_vld, 1'b0);

    // Abort after 5 bits, restart with same-cycle bit 0, gap mid-frame
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, (i % 2 == 0), 1'b1, 1'b1);
    check("t4_busy", bus0.busy, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < W - 1; i++) begin
      if (i == 3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
    end
    if (NB > W) cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("t4_dout_lsb", bus0.dout, 8'hFF);
    check("t4_dout_msb", bus1.dout, 8'hFF);
    check("t4_ovr", bus0.overrun, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_vld_drop", bus0.dout_vld, 1'b0);

    // Back-to-back: accept and reload on the same edge
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    check("t5_dout_a", bus0.dout, 8'h5A);
    send_word(8'h36, 1'b0, 1'b1, 1'b0);
    check("t5_dout_lsb", bus0.dout, 8'h36);
    check("t5_dout_msb", bus1.dout, 8'h6C);
    check("t5_vld", bus0.dout_vld, 1'b1);
    check("t5_ovr", bus0.overrun, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_vld_drop", bus0.dout_vld, 1'b0);

`ifdef SIPO_FRAME_PARITY_EN
    send_word(8'h4D, 1'b1, 1'b1, 1'b0);
    check("t6_perr_ok", bus0.parity_err, 1'b0);
    check("t6_dout_ok", bus0.dout, 8'h4D);
    send_word(8'h4D, 1'b1, 1'b1, 1'b1);
    check("t6_perr_bad", bus0.parity_err, 1'b1);
    check("t6_dout_bad", bus0.dout, 8'h4D);
    check("t6_vld_bad", bus0.dout_vld, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_perr_pulse", bus0.parity_err, 1'b0);
`endif

    // Asynchronous reset mid-frame with a pending word
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    check("rst2_pre_vld", bus0.dout_vld, 1'b1);
    rst_ = 1'b0;
    #1;
    check("rst2_dout_lsb", bus0.dout, 8'h00);
    check("rst2_dout_msb", bus1.dout, 8'h00);
    check("rst2_vld", bus0.dout_vld, 1'b0);
    check("rst2_busy", bus0.busy, 1'b0);
    check("rst2_ovr", bus0.overrun, 1'b0);
    check("rst2_perr", bus0.parity_err, 1'b0);
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst_ = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
